// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
//
// Byte-stream front end for the 8-bit SHA-256 core. Message bytes arrive one
// per cycle and are packed big-endian into 32-bit words. The words go to the
// compression core as 16-word blocks. FIPS 180-4 padding is added in-line:
// first 0x80, then zero fill, then the 64-bit bit length. No whole block is
// ever buffered; a single word register is the only holding storage.
//
// Parameters
//   LEN_W      width of the bit-length counter (8..64). Length bits at and
//              above LEN_W are sent as zero.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_data    message byte
//   in_valid   in_data valid
//   in_last    final byte of the message (only meaningful with in_valid)
//   in_ready   padder accepts a byte this cycle
//   blk_word   block word to core, big-endian
//   blk_valid  blk_word valid
//   blk_ready  core consumes blk_word this cycle
//   blk_first  blk_word is word 0 of a block
//   blk_end    blk_word is word 15 of a block
//   msg_end    blk_word is word 15 of the final block
//   len_ovf    (only with SHA256_PAD_OVF_EN) sticky bit-length wrap flag.
//              It is cleared by rst or when the msg_end word transfers.
//
// Build option
//   SHA256_PAD_OVF_EN  when defined, adds the len_ovf output. When undefined,
//                      the length silently wraps modulo 2^LEN_W.

module sha256_msg_padder #(
  parameter int unsigned LEN_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] blk_word,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic        blk_first,
  output logic        blk_end,
  output logic        msg_end
`ifdef SHA256_PAD_OVF_EN
  ,
  output logic        len_ovf
`endif
);

  // The state names what gets emitted when the word now held is consumed:
  //   StData  : nothing, go back to collecting bytes
  //   StPad   : the 0x80000000 word (message ended on a word boundary)
  //   StZero  : zero words, or the high length word once index 14 is next
  //   StLenHi : the low length word (index 15, msg_end)
  //   StLenLo : message finished, clear counters
  typedef enum logic [2:0] {
    StData,
    StPad,
    StZero,
    StLenHi,
    StLenLo
  } state_e;

  localparam logic [LEN_W:0] ByteBits = (LEN_W + 1)'(8);

  state_e           state_q;
  logic [23:0]      acc_q;       // up to three earlier bytes of the word being packed
  logic [1:0]       byte_cnt_q;  // bytes already held in acc_q
  logic [3:0]       word_idx_q;  // block index of the word being packed or presented
  logic [LEN_W-1:0] bit_len_q;
  logic [31:0]      word_q;
  logic             valid_q;
  logic             first_q;
  logic             end_q;
  logic             msg_end_q;
`ifdef SHA256_PAD_OVF_EN
  logic             len_ovf_q;
`endif

  logic             byte_acc;
  logic             word_xfer;
  logic [3:0]       next_idx;
  logic [LEN_W:0]   len_sum;
  logic [63:0]      len64;
  logic [31:0]      data_word;
  logic [31:0]      fill_word;
  logic             fill_valid;
  logic             fill_msg_end;
  state_e           fill_state;

  // in_ready depends only on registers and rst. This keeps the byte
  // handshake free of any combinational path from in_valid.
  assign in_ready  = (state_q == StData) && !valid_q && !rst;
  assign byte_acc  = in_valid && in_ready;
  assign word_xfer = valid_q && blk_ready;
  assign next_idx  = word_idx_q + 4'd1;
  assign len_sum   = {1'b0, bit_len_q} + ByteBits;
  assign len64     = 64'(bit_len_q);

  // Completed data word. A short final word gets the 0x80 marker right after
  // its last byte, and the rest of the word is zero.
  always_comb begin
    data_word = {acc_q, in_data};
    if (in_last) begin
      case (byte_cnt_q)
        2'd0:    data_word = {in_data, 8'h80, 16'h0000};
        2'd1:    data_word = {acc_q[7:0], in_data, 8'h80, 8'h00};
        2'd2:    data_word = {acc_q[15:0], in_data, 8'h80};
        default: data_word = {acc_q, in_data};
      endcase
    end
  end

  // Word that replaces the held one when the core consumes it.
  always_comb begin
    fill_word    = 32'h0000_0000;
    fill_valid   = 1'b1;
    fill_msg_end = 1'b0;
    fill_state   = state_q;
    case (state_q)
      StData: begin
        fill_valid = 1'b0;
      end
      StPad: begin
        fill_word  = 32'h8000_0000;
        fill_state = StZero;
      end
      StZero: begin
        // A padded word at index 14 or 15 leaves no room for the length field.
        // Zero fill then carries on into the next block until index 14 is reached.
        if (next_idx == 4'd14) begin
          fill_word  = len64[63:32];
          fill_state = StLenHi;
        end
      end
      StLenHi: begin
        fill_word    = len64[31:0];
        fill_msg_end = 1'b1;
        fill_state   = StLenLo;
      end
      StLenLo: begin
        fill_valid = 1'b0;
        fill_state = StData;
      end
      default: begin
        fill_valid = 1'b0;
        fill_state = StData;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StData;
      acc_q      <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      bit_len_q  <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      end_q      <= 1'b0;
      msg_end_q  <= 1'b0;
`ifdef SHA256_PAD_OVF_EN
      len_ovf_q  <= 1'b0;
`endif
    end else begin
      // byte_acc and word_xfer never fire together: in_ready requires an
      // empty holding register.
      if (byte_acc) begin
        bit_len_q <= len_sum[LEN_W-1:0];
`ifdef SHA256_PAD_OVF_EN
        if (len_sum[LEN_W]) begin
          len_ovf_q <= 1'b1;
        end
`endif
        if (in_last || (byte_cnt_q == 2'd3)) begin
          word_q     <= data_word;
          valid_q    <= 1'b1;
          first_q    <= (word_idx_q == 4'd0);
          end_q      <= (word_idx_q == 4'd15);
          msg_end_q  <= 1'b0;
          acc_q      <= '0;
          byte_cnt_q <= '0;
          if (in_last) begin
            state_q <= (byte_cnt_q == 2'd3) ? StPad : StZero;
          end
        end else begin
          acc_q      <= {acc_q[15:0], in_data};
          byte_cnt_q <= byte_cnt_q + 2'd1;
        end
      end

      if (word_xfer) begin
        word_q     <= fill_word;
        valid_q    <= fill_valid;
        first_q    <= fill_valid && (next_idx == 4'd0);
        end_q      <= fill_valid && (next_idx == 4'd15);
        msg_end_q  <= fill_msg_end;
        state_q    <= fill_state;
        word_idx_q <= next_idx;
        if (state_q == StLenLo) begin
          // msg_end word consumed: the next message starts from a clean slate.
          word_idx_q <= '0;
          bit_len_q  <= '0;
          acc_q      <= '0;
          byte_cnt_q <= '0;
`ifdef SHA256_PAD_OVF_EN
          len_ovf_q  <= 1'b0;
`endif
        end
      end
    end
  end

  assign blk_word  = word_q;
  assign blk_valid = valid_q;
  assign blk_first = first_q;
  assign blk_end   = end_q;
  assign msg_end   = msg_end_q;
`ifdef SHA256_PAD_OVF_EN
  assign len_ovf   = len_ovf_q;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Testbench for sha256_msg_padder. It runs table-driven messages through a
// 32-bit-length instance and an 8-bit-length instance. Both instances share
// the same stimulus.
module tb_sha256_msg_padder;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        blk_ready;

  logic        in_ready, blk_valid, blk_first, blk_end, msg_end;
  logic [31:0] blk_word;
  logic        in_ready8, b8_valid, b8_first, b8_end, b8_msg_end;
  logic [31:0] b8_word;
`ifdef SHA256_PAD_OVF_EN
  logic        len_ovf32, len_ovf8;
`endif

  sha256_msg_padder #(.LEN_W(32)) dut (
`ifdef SHA256_PAD_OVF_EN
    .len_ovf   (len_ovf32),
`endif
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_word  (blk_word),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_first (blk_first),
    .blk_end   (blk_end),
    .msg_end   (msg_end)
  );

  sha256_msg_padder #(.LEN_W(8)) dut8 (
`ifdef SHA256_PAD_OVF_EN
    .len_ovf   (len_ovf8),
`endif
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready8),
    .blk_word  (b8_word),
    .blk_valid (b8_valid),
    .blk_ready (blk_ready),
    .blk_first (b8_first),
    .blk_end   (b8_end),
    .msg_end   (b8_msg_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int unsigned len;
    logic [7:0]  b0;        // message byte i is b0 + i
    int unsigned nwords;
    int unsigned stall_at;  // word index held under blk_ready=0
    int unsigned stall_cyc;
    int unsigned sidx [3];  // hand-computed spot words
    logic [31:0] sval [3];
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [34:0] cap_q [$];
  logic [34:0] cap8_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input int unsigned len, input logic [7:0] b0,
                              input int unsigned nw, input int unsigned sa,
                              input int unsigned sc,
                              input int unsigned i0, input logic [31:0] v0,
                              input int unsigned i1, input logic [31:0] v1,
                              input int unsigned i2, input logic [31:0] v2);
    vec_t v;
    v.len = len; v.b0 = b0; v.nwords = nw; v.stall_at = sa; v.stall_cyc = sc;
    v.sidx[0] = i0; v.sval[0] = v0;
    v.sidx[1] = i1; v.sval[1] = v1;
    v.sidx[2] = i2; v.sval[2] = v2;
    return v;
  endfunction

  // Reference padding: message, 0x80, zeros up to 56 mod 64, then the
  // 64-bit big-endian bit length truncated to lenw bits.
  function automatic int unsigned padded_len(input int unsigned len);
    return ((len + 8) / 64 + 1) * 64;
  endfunction

  function automatic logic [7:0] pad_byte(input int unsigned len, input logic [7:0] b0,
                                          input int unsigned i, input int unsigned lenw);
    int unsigned plen;
    logic [63:0] bits;
    plen = padded_len(len);
    bits = 64'(len) * 64'd8;
    if (lenw < 64) bits = bits & ((64'd1 << lenw) - 64'd1);
    if (i < len) return 8'(int'(b0) + int'(i));
    if (i == len) return 8'h80;
    if (i >= plen - 8) return bits[8*(plen-1-i) +: 8];
    return 8'h00;
  endfunction

  function automatic logic [31:0] exp_word(input int unsigned len, input logic [7:0] b0,
                                           input int unsigned j, input int unsigned lenw);
    return {pad_byte(len, b0, 4*j, lenw), pad_byte(len, b0, 4*j+1, lenw),
            pad_byte(len, b0, 4*j+2, lenw), pad_byte(len, b0, 4*j+3, lenw)};
  endfunction

  task automatic run_msg(input int unsigned len, input logic [7:0] b0,
                         input int unsigned stall_at, input int unsigned stall_cyc,
                         output bit done);
    int unsigned pos, cyc, stall_left;
    logic [31:0] sw;
    pos = 0; cyc = 0; done = 1'b0; stall_left = stall_cyc;
    cap_q.delete();
    cap8_q.delete();
    sw = exp_word(len, b0, stall_at, 32);
    while (!done && cyc < 40*len + 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("in_ready at message start", in_ready, 1);
        chk("in_ready8 at message start", in_ready8, 1);
      end
      blk_ready = 1'b1;
      if (blk_valid && stall_left > 0 && cap_q.size() == int'(stall_at)) begin
        blk_ready = 1'b0;
        stall_left--;
        chk($sformatf("stalled word %0d", stall_at), blk_word, sw);
        chk("in_ready while stalled", in_ready, 0);
      end
      if (blk_valid && blk_ready) begin
        cap_q.push_back({blk_first, blk_end, msg_end, blk_word});
        if (msg_end) done = 1'b1;
      end
      if (b8_valid && blk_ready) cap8_q.push_back({b8_first, b8_end, b8_msg_end, b8_word});
      if (pos < len) begin
        in_valid = 1'b1;
        in_data  = 8'(int'(b0) + int'(pos));
        in_last  = (pos == len - 1);
        if (in_ready) pos++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    bit done;
    int unsigned nw;
    logic [34:0] e;
    logic [31:0] a;
    run_msg(v.len, v.b0, v.stall_at, v.stall_cyc, done);
    chk({tag, " reached msg_end"}, done, 1);
    chk({tag, " word count"}, cap_q.size(), v.nwords);
    nw = padded_len(v.len) / 4;
    for (int j = 0; j < cap_q.size(); j++) begin
      e = {(j % 16) == 0, (j % 16) == 15, j == int'(v.nwords) - 1,
           exp_word(v.len, v.b0, j, 32)};
      chk($sformatf("%s word %0d {first,end,msg_end,word}", tag, j), cap_q[j], e);
    end
    for (int k = 0; k < 3; k++) begin
      a = (v.sidx[k] < cap_q.size()) ? cap_q[v.sidx[k]][31:0] : 32'hxxxx_xxxx;
      chk($sformatf("%s spot word %0d", tag, v.sidx[k]), a, v.sval[k]);
    end
    chk({tag, " LEN_W=8 word count"}, cap8_q.size(), nw);
    a = (cap8_q.size() == nw) ? cap8_q[nw-1][31:0] : 32'hxxxx_xxxx;
    chk({tag, " LEN_W=8 length word"}, a, exp_word(v.len, v.b0, nw - 1, 8));
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = mk(3,  8'h61, 16, 0, 0,  0, 32'h61626380, 14, 32'h0, 15, 32'h18);
    vecs[1] = mk(4,  8'h61, 16, 1, 4,  0, 32'h61626364, 1, 32'h80000000, 15, 32'h20);
    vecs[2] = mk(8,  8'h61, 16, 0, 5,  0, 32'h61626364, 2, 32'h80000000, 15, 32'h40);
    vecs[3] = mk(55, 8'h00, 16, 0, 0,  13, 32'h34353680, 14, 32'h0, 15, 32'h1B8);
    vecs[4] = mk(56, 8'h00, 32, 14, 3, 14, 32'h80000000, 15, 32'h0, 31, 32'h1C0);
    vecs[5] = mk(63, 8'h00, 32, 0, 0,  15, 32'h3C3D3E80, 16, 32'h0, 31, 32'h1F8);
    vecs[6] = mk(64, 8'h00, 32, 0, 0,  15, 32'h3C3D3E3F, 16, 32'h80000000, 31, 32'h200);
    vecs[7] = mk(1,  8'hFF, 16, 0, 0,  0, 32'hFF800000, 1, 32'h0, 15, 32'h8);

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; blk_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset blk_word", blk_word, 0);
    chk("reset blk_valid", blk_valid, 0);
    chk("reset flags {first,end,msg_end}", {blk_first, blk_end, msg_end}, 0);
    chk("reset in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("in_ready after reset", in_ready, 1);

    for (int i = 0; i < 8; i++) check_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a block while a data word is held.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(8'h10 + k); in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid-msg word held", {blk_valid, blk_word}, {1'b1, 32'h10111213});
    rst = 1'b1;
    #1;
    chk("in_ready during rst", in_ready, 0);
    @(negedge clk);
    chk("after mid-msg rst {valid,word}", {blk_valid, blk_word}, 0);
    chk("after mid-msg rst flags", {blk_first, blk_end, msg_end}, 0);
    rst = 1'b0;
    in_last = 1'b1;  // in_last without in_valid must be ignored
    #1;
    chk("in_ready after mid-msg rst", in_ready, 1);
    @(negedge clk);
    chk("lone in_last ignored", blk_valid, 0);
    in_last = 1'b0;
    check_vec(vecs[0], "abc after rst");

    // 32 bytes: the 8-bit counter wraps to 0 on the last byte.
    check_vec(mk(32, 8'h00, 16, 0, 0, 7, 32'h1C1D1E1F, 8, 32'h80000000, 15, 32'h100),
              "len32");
    chk("LEN_W=8 zero length word", (cap8_q.size() == 16) ? cap8_q[15][31:0] : 32'hx, 0);
`ifdef SHA256_PAD_OVF_EN
    chk("len_ovf8 set at msg_end", len_ovf8, 1);
    chk("len_ovf32 clear", len_ovf32, 0);
    @(negedge clk);
    chk("len_ovf8 cleared after msg_end", len_ovf8, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
